// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store access unit: MemOp codes, fault codes
// and the transaction FSM states.
package lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ILLEGAL  = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RSP  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/lsu_access_if.sv
// Data-memory bus between the access unit (master) and memory (slave):
// one valid/ready request channel and a valid-only response channel.
interface lsu_access_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wmask;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store lane replication and strobes, load extract/extend,
// and legality/alignment checks. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wmask,
    output logic [31:0] ld_data,
    output logic        illegal,
    output logic        misalign
);

    logic [31:0] shifted;

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        case (op)
            MEMOP_B:  ;
            MEMOP_H:  misalign = addr_lo[0];
            MEMOP_W:  misalign = |addr_lo;
            MEMOP_BU: illegal  = is_store;
            MEMOP_HU: begin
                illegal  = is_store;
                misalign = addr_lo[0];
            end
            default:  illegal  = 1'b1;
        endcase
    end

    // Narrow stores replicate the datum so the strobe alone selects the lane.
    always_comb begin
        st_wdata = wdata;
        st_wmask = 4'b1111;
        case (op)
            MEMOP_B: begin
                st_wdata = {4{wdata[7:0]}};
                st_wmask = 4'b0001 << addr_lo;
            end
            MEMOP_H: begin
                st_wdata = {2{wdata[15:0]}};
                st_wmask = 4'b0011 << addr_lo;
            end
            default: ;
        endcase
    end

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (op)
            MEMOP_B:  ld_data = {{24{shifted[7]}},  shifted[7:0]};
            MEMOP_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            MEMOP_BU: ld_data = {24'h0, shifted[7:0]};
            MEMOP_HU: ld_data = {16'h0, shifted[15:0]};
            default:  ;
        endcase
    end

endmodule

// File: rtl/lsu_access.sv
// Load/store access unit: runs one data-memory transaction per accepted
// instruction and returns extended load data or a fault to writeback.
module lsu_access
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             MemWr,
    input  logic             MemtoReg,
    input  logic [2:0]       MemOp,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  wdata,
    lsu_access_if.master     mem,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [XLEN-1:0]  load_data,
    output logic [1:0]       fault
);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [2:0]      op_q, op_d;
    logic            store_q, store_d;
    fault_e          fault_q, fault_d;

    logic            idle, in_req, timed_out;
    logic            al_store;
    logic [2:0]      al_op;
    logic [1:0]      al_lo;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] st_wdata, ld_data;
    logic [3:0]      st_wmask;
    logic            illegal, misalign;

    assign idle   = (state_q == ST_IDLE);
    assign in_req = (state_q == ST_REQ);

    // In IDLE the checks look at the live request so faults resolve on accept;
    // afterwards the lane logic works from the latched copy.
    assign al_store = idle ? MemWr       : store_q;
    assign al_op    = idle ? MemOp       : op_q;
    assign al_lo    = idle ? addr[1:0]   : addr_q[1:0];
    assign al_wdata = idle ? wdata       : wdata_q;

    lsu_align u_align (
        .is_store (al_store),
        .op       (al_op),
        .addr_lo  (al_lo),
        .wdata    (al_wdata),
        .rdata    (mem.mem_rsp_rdata),
        .st_wdata (st_wdata),
        .st_wmask (st_wmask),
        .ld_data  (ld_data),
        .illegal  (illegal),
        .misalign (misalign)
    );

    assign cnt_inc   = cnt_q + 1'b1;
    assign timed_out = (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        store_d     = store_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && (MemWr || MemtoReg)) begin
                    addr_d      = addr;
                    wdata_d     = wdata;
                    op_d        = MemOp;
                    store_d     = MemWr;
                    load_data_d = '0;
                    cnt_d       = '0;
                    if (illegal) begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = ST_DONE;
                    end else if (misalign) begin
                        fault_d = FAULT_MISALIGN;
                        state_d = ST_DONE;
                    end else begin
                        fault_d = FAULT_NONE;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RSP;
                end else begin
                    cnt_d = cnt_inc;
                    if (timed_out) begin
                        fault_d = FAULT_TIMEOUT;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RSP: begin
                if (mem.mem_rsp_valid) begin
                    load_data_d = store_q ? '0 : ld_data;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (timed_out) begin
                        fault_d = FAULT_TIMEOUT;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (done_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= '0;
            store_q     <= 1'b0;
            load_data_q <= '0;
            fault_q     <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            store_q     <= store_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    assign req_ready         = idle;
    assign mem.mem_req_valid = in_req;
    assign mem.mem_addr      = {addr_q[XLEN-1:2], 2'b00};
    assign mem.mem_wen       = in_req && store_q;
    assign mem.mem_wdata     = (in_req && store_q) ? st_wdata : '0;
    assign mem.mem_wmask     = (in_req && store_q) ? st_wmask : 4'b0000;
    assign done_valid        = (state_q == ST_DONE);
    assign load_data         = load_data_q;
    assign fault             = fault_q;

endmodule

// File: tb/tb_lsu_access.sv
// Directed bench for lsu_access: a bus responder, a transaction-level model
// of expected results, and a per-cycle compare process.
module tb_lsu_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemWr = 1'b0;
    logic        MemtoReg = 1'b0;
    logic [2:0]  MemOp = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [31:0] load_data;
    logic [1:0]  fault;

    lsu_access_if #(.XLEN(32)) mem_if ();

    lsu_access #(.XLEN(32), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemWr      (MemWr),
        .MemtoReg   (MemtoReg),
        .MemOp      (MemOp),
        .addr       (addr),
        .wdata      (wdata),
        .mem        (mem_if),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .load_data  (load_data),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- model: results from the access rules ----------------
    function automatic int size_of(input bit st, input logic [2:0] op);
        case (op)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b100:  return st ? 0 : 1;
            3'b101:  return st ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] m_fault(input bit st, input logic [2:0] op, input logic [31:0] a);
        int sz = size_of(st, op);
        if (sz == 0) return 2'b10;
        if ((a % sz) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
        int sz = size_of(1'b0, op);
        int off = int'(a[1:0]);
        logic [63:0] v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!op[2] && v[8*sz-1]) v = v | (~64'h0 << (8*sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
        int sz = size_of(1'b1, op);
        logic [31:0] r = '0;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % sz) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] op, input logic [31:0] a);
        logic [3:0] m = 4'((1 << size_of(1'b1, op)) - 1);
        return m << a[1:0];
    endfunction

    // expectations for the transaction in flight
    logic        e_st;
    logic [31:0] e_addr, e_wd, e_ld;
    logic [3:0]  e_mask;
    logic [1:0]  e_fault;
    int          e_reqc, e_lat;
    bit          chk_en = 1'b0;
    int          req_seen = 0;
    logic [31:0] last_addr, last_wdata, last_ld;
    logic [3:0]  last_wmask;
    logic [1:0]  last_fault;

    // ---------------- bus responder ----------------
    int          rs_stall = 0, rs_delay = 0, rs_cnt = 0;
    bit          rs_armed = 1'b0, rs_early = 1'b0, rs_pulse = 1'b0;
    logic [31:0] rs_rdata = '0;

    initial begin
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_if.mem_req_ready = 1'b0;
            mem_if.mem_rsp_valid = 1'b0;
            if (rs_pulse) begin
                mem_if.mem_rsp_valid = 1'b1;
                mem_if.mem_rsp_rdata = 32'hDEADBEEF;
                rs_pulse = 1'b0;
            end else if (rs_armed && rs_delay >= 0) begin
                if (rs_cnt == 0) begin
                    mem_if.mem_rsp_valid = 1'b1;
                    mem_if.mem_rsp_rdata = rs_rdata;
                    rs_armed = 1'b0;
                end else rs_cnt--;
            end
            if (mem_if.mem_req_valid) begin
                if (rs_stall > 0) rs_stall--;
                else begin
                    mem_if.mem_req_ready = 1'b1;
                    rs_armed = 1'b1;
                    rs_cnt = rs_delay;
                    if (rs_early) begin
                        mem_if.mem_rsp_valid = 1'b1;
                        mem_if.mem_rsp_rdata = 32'hDEADBEEF;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                if (mem_if.mem_req_valid) begin
                    req_seen++;
                    chk("bus_addr", mem_if.mem_addr, {e_addr[31:2], 2'b00});
                    chk("bus_wen", {31'b0, mem_if.mem_wen}, {31'b0, e_st});
                    chk("bus_wmask", {28'b0, mem_if.mem_wmask}, e_st ? {28'b0, e_mask} : 32'h0);
                    if (e_st) chk("bus_wdata", mem_if.mem_wdata, e_wd);
                    last_addr  = mem_if.mem_addr;
                    last_wdata = mem_if.mem_wdata;
                    last_wmask = mem_if.mem_wmask;
                end
                if (done_valid) begin
                    chk("done_load", load_data, e_ld);
                    chk("done_fault", {30'b0, fault}, {30'b0, e_fault});
                    chk("done_noreq", {31'b0, mem_if.mem_req_valid}, 32'h0);
                end
            end
        end
    end

    task automatic do_txn(input string nm, input bit wr, input bit ld, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int stall, input int rdly, input int hold, input bit early);
        int rspc, lat;
        e_st = wr; e_addr = a; e_ld = '0;
        e_fault = m_fault(wr, op, a);
        e_reqc = 0; rspc = 0;
        if (e_fault == 2'b00) begin
            e_wd = m_wdata(op, wd);
            e_mask = m_mask(op, a);
            if (stall >= TO) begin
                e_reqc = TO; e_fault = 2'b11;
            end else begin
                e_reqc = stall + 1;
                if (rdly < 0 || rdly >= TO) begin
                    rspc = TO; e_fault = 2'b11;
                end else begin
                    rspc = rdly + 1;
                    if (!wr) e_ld = m_load(op, a, rd);
                end
            end
        end
        e_lat = e_reqc + rspc + 1;
        rs_stall = stall; rs_delay = rdly; rs_rdata = rd; rs_early = early; rs_armed = 1'b0;
        req_seen = 0; chk_en = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; MemWr = wr; MemtoReg = ld; MemOp = op; addr = a; wdata = wd;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        chk({nm, "_accept"}, {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0; addr = ~a; wdata = ~wd; MemOp = 3'b111;
            end
            if (done_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, lat, e_lat);
        chk({nm, "_reqcycles"}, req_seen, e_reqc);
        chk({nm, "_busy"}, {31'b0, req_ready}, 32'h0);
        last_ld = load_data; last_fault = fault;
        for (int i = 0; i < hold; i++) @(negedge clk);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk({nm, "_released"}, {31'b0, done_valid}, 32'h0);
        chk({nm, "_idle"}, {31'b0, req_ready}, 32'h1);
        chk_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mem_req", {31'b0, mem_if.mem_req_valid}, 32'h0);
        chk("rst_done", {31'b0, done_valid}, 32'h0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_fault", {30'b0, fault}, 32'h0);
        chk("rst_wmask", {28'b0, mem_if.mem_wmask}, 32'h0);
        chk("rst_addr", mem_if.mem_addr, 32'h0);
        rst_n = 1'b1;

        // neither load nor store: ignored
        @(negedge clk);
        req_valid = 1'b1; MemWr = 1'b0; MemtoReg = 1'b0; MemOp = 3'b010;
        repeat (3) begin
            @(negedge clk);
            chk("nop_ready", {31'b0, req_ready}, 32'h1);
            chk("nop_bus", {31'b0, mem_if.mem_req_valid | done_valid}, 32'h0);
        end
        req_valid = 1'b0;

        //      name    wr ld op      addr           wdata          rdata       stall rdly hold early
        do_txn("lb",    0, 1, 3'b000, 32'h80000003, 32'h0,        32'h80FF1234, 0, 0, 0, 0);
        chk("lb_value", last_ld, 32'hFFFFFF80);
        do_txn("lbu",   0, 1, 3'b100, 32'h80000003, 32'h0,        32'h80FF1234, 0, 0, 0, 0);
        chk("lbu_value", last_ld, 32'h00000080);
        do_txn("lh",    0, 1, 3'b001, 32'h80000002, 32'h0,        32'h8001ABCD, 0, 0, 0, 0);
        chk("lh_value", last_ld, 32'hFFFF8001);
        do_txn("lhu",   0, 1, 3'b101, 32'h80000002, 32'h0,        32'h8001ABCD, 0, 0, 0, 0);
        chk("lhu_value", last_ld, 32'h00008001);
        do_txn("lh_mis",0, 1, 3'b001, 32'h80000001, 32'h0,        32'h8001ABCD, 0, 0, 0, 0);
        chk("lh_mis_fault", {30'b0, last_fault}, 32'h1);
        do_txn("sb",    1, 0, 3'b000, 32'h80000002, 32'h000000A5, 32'h0,        0, 0, 0, 0);
        chk("sb_wmask", {28'b0, last_wmask}, 32'h4);
        chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
        chk("sb_addr", last_addr, 32'h80000000);
        do_txn("sw_ill",1, 0, 3'b100, 32'h80000000, 32'h12345678, 32'h0,        0, 0, 0, 0);
        chk("sw_ill_fault", {30'b0, last_fault}, 32'h2);
        do_txn("lw_bp", 0, 1, 3'b010, 32'h80000004, 32'h0,        32'h12345678, 3, 0, 0, 0);
        chk("lw_bp_value", last_ld, 32'h12345678);
        do_txn("lw_to", 0, 1, 3'b010, 32'h80000008, 32'h0,        32'h12345678, 0, -1, 0, 0);
        chk("lw_to_fault", {30'b0, last_fault}, 32'h3);
        chk("lw_to_load", last_ld, 32'h0);
        do_txn("rq_to", 1, 0, 3'b010, 32'h8000000C, 32'hCAFEF00D, 32'h0,        100, 0, 0, 0);
        do_txn("sh",    1, 0, 3'b001, 32'h80000002, 32'h0000BEEF, 32'h0,        0, 1, 5, 0);
        chk("sh_wmask", {28'b0, last_wmask}, 32'hC);
        chk("sh_wdata", last_wdata, 32'hBEEFBEEF);
        do_txn("lb_hold",0,1, 3'b000, 32'h00000001, 32'h0,        32'h0000F000, 0, 2, 5, 0);
        do_txn("both",  1, 1, 3'b101, 32'h80000000, 32'h0,        32'h0,        0, 0, 0, 0);
        do_txn("sw_mis",1, 0, 3'b010, 32'h80000002, 32'h11223344, 32'h0,        0, 0, 0, 0);
        do_txn("lw_bad",0, 1, 3'b011, 32'h80000000, 32'h0,        32'h0,        0, 0, 0, 0);
        do_txn("early", 0, 1, 3'b010, 32'h80000010, 32'h0,        32'h0BADF00D, 0, 0, 0, 1);
        do_txn("lw_slow",0,1, 3'b010, 32'h80000014, 32'h0,        32'h55AA55AA, 1, 3, 0, 0);

        // reset while waiting for a response, then a stray response in IDLE
        rs_stall = 0; rs_delay = -1; rs_early = 1'b0; rs_armed = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; MemWr = 1'b0; MemtoReg = 1'b1; MemOp = 3'b010; addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rsp_state", {31'b0, mem_if.mem_req_valid | done_valid | req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, req_ready}, 32'h1);
        chk("arst_mem_req", {31'b0, mem_if.mem_req_valid}, 32'h0);
        chk("arst_done", {31'b0, done_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rs_armed = 1'b0;
        rs_pulse = 1'b1;
        repeat (3) @(negedge clk);
        chk("late_rsp_done", {31'b0, done_valid}, 32'h0);
        chk("late_rsp_ready", {31'b0, req_ready}, 32'h1);
        chk("late_rsp_fault", {30'b0, fault}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
